// File: rtl/colisor_tiro_pkg.sv
// Shared constants, state encoding and board-index helpers for the shot-resolution stage.
package colisor_tiro_pkg;

  localparam int GRID      = 8;
  localparam int COORD_W   = 4;
  localparam int MAX_SHIPS = 8;
  localparam int CELLS     = GRID * GRID;
  localparam int IDX_W     = $clog2(CELLS);
  localparam int CNT_W     = 4;

  // First illegal coordinate; doubles as the "no coordinate" marker from the controller.
  localparam logic [COORD_W-1:0] COORD_NONE = COORD_W'(GRID);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHECK   = 2'd1,
    RESOLVE = 2'd2
  } state_t;

  function automatic logic [IDX_W-1:0] idx(input logic [COORD_W-1:0] x,
                                           input logic [COORD_W-1:0] y);
    return IDX_W'(y * GRID + x);
  endfunction

  function automatic logic in_range(input logic [COORD_W-1:0] x,
                                    input logic [COORD_W-1:0] y);
    return (x < COORD_NONE) && (y < COORD_NONE);
  endfunction

endpackage

// File: rtl/colisor_tiro_board_bank.sv
// One player's fleet board: occupied and hit bitmaps plus the count of unhit occupied cells.
module board_bank
  import colisor_tiro_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [IDX_W-1:0] addr,
  input  logic             set_occ,
  input  logic             set_hit,
  input  logic             dec,
  output logic             occ,
  output logic             hit,
  output logic [CNT_W-1:0] count
);

  logic [CELLS-1:0] occ_map;
  logic [CELLS-1:0] hit_map;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_map <= '0;
      hit_map <= '0;
      count   <= '0;
    end else if (clear) begin
      occ_map <= '0;
      hit_map <= '0;
      count   <= '0;
    end else begin
      if (set_occ) occ_map[addr] <= 1'b1;
      if (set_hit) hit_map[addr] <= 1'b1;
      // Placement and hits never coincide (IDLE vs RESOLVE), so inc/dec need no merge.
      if (set_occ && (count != CNT_W'(MAX_SHIPS)))
        count <= count + 1'b1;
      else if (dec && (count != '0))
        count <= count - 1'b1;
    end
  end

  assign occ = occ_map[addr];
  assign hit = hit_map[addr];

endmodule

// File: rtl/colisor_tiro.sv
// Shot-resolution stage: owns both fleet boards, resolves controller shots, reports hit flags and counts.
//
// state   | meaning
// IDLE    | accepting placements; waiting for a shot_req rising edge
// CHECK   | range test on latched shot, read defender occupied/hit bits
// RESOLVE | update defender board, register flags, pulse shot_done
module colisor_tiro
  import colisor_tiro_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               place_we,
  input  logic               place_player,
  input  logic [COORD_W-1:0] place_x,
  input  logic [COORD_W-1:0] place_y,
  output logic               place_ack,
  output logic               place_err,
  input  logic               shot_req,
  input  logic               shot_player,
  input  logic [COORD_W-1:0] shot_x,
  input  logic [COORD_W-1:0] shot_y,
  output logic               busy,
  output logic               shot_done,
  output logic               acertou_tiro,
  output logic               repeat_shot,
  output logic               invalid_shot,
  output logic [3:0]         qtd_p1,
  output logic [3:0]         qtd_p2
);

  state_t state, state_nx;

  logic               shot_req_q;
  logic               rise;
  logic               sh_player;
  logic [COORD_W-1:0] sh_x;
  logic [COORD_W-1:0] sh_y;
  logic               defender;
  logic               chk_range;
  logic               chk_occ;
  logic               chk_hit;

  logic [IDX_W-1:0]   bank_addr;
  logic [1:0]         occ_b;
  logic [1:0]         hit_b;
  logic [1:0]         set_occ_b;
  logic [1:0]         set_hit_b;
  logic [1:0]         dec_b;
  logic [1:0][CNT_W-1:0] count_b;

  logic latch_shot;
  logic place_valid;
  logic place_ok;
  logic place_rej;
  logic res_done;
  logic res_hit;
  logic res_rep;
  logic res_inv;

  assign rise     = shot_req & ~shot_req_q;
  assign defender = ~sh_player;
  // Boards are addressed by the placement port while idle and by the latched shot otherwise.
  assign bank_addr = (state == IDLE) ? idx(place_x, place_y) : idx(sh_x, sh_y);

  board_bank u_board_p1 (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .addr    (bank_addr),
    .set_occ (set_occ_b[0]),
    .set_hit (set_hit_b[0]),
    .dec     (dec_b[0]),
    .occ     (occ_b[0]),
    .hit     (hit_b[0]),
    .count   (count_b[0])
  );

  board_bank u_board_p2 (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .addr    (bank_addr),
    .set_occ (set_occ_b[1]),
    .set_hit (set_hit_b[1]),
    .dec     (dec_b[1]),
    .occ     (occ_b[1]),
    .hit     (hit_b[1]),
    .count   (count_b[1])
  );

  assign place_valid = in_range(place_x, place_y) && !occ_b[place_player] &&
                       (count_b[place_player] != CNT_W'(MAX_SHIPS));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     state <= IDLE;
    else if (clear) state <= IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    latch_shot = 1'b0;
    place_ok   = 1'b0;
    place_rej  = 1'b0;
    set_occ_b  = '0;
    set_hit_b  = '0;
    dec_b      = '0;
    res_done   = 1'b0;
    res_hit    = 1'b0;
    res_rep    = 1'b0;
    res_inv    = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          latch_shot = 1'b1;
          state_nx   = CHECK;
        end
        // A shot edge in the same cycle takes the board port, so the write loses.
        if (place_we) begin
          if (!rise && place_valid) begin
            place_ok                = 1'b1;
            set_occ_b[place_player] = 1'b1;
          end else begin
            place_rej = 1'b1;
          end
        end
      end
      CHECK: begin
        place_rej = place_we;
        state_nx  = RESOLVE;
      end
      RESOLVE: begin
        place_rej = place_we;
        res_done  = 1'b1;
        state_nx  = IDLE;
        if (!chk_range) begin
          res_inv = 1'b1;
        end else if (chk_occ && !chk_hit) begin
          res_hit             = 1'b1;
          set_hit_b[defender] = 1'b1;
          dec_b[defender]     = 1'b1;
        end else if (chk_occ) begin
          res_rep = 1'b1;
        end else begin
          set_hit_b[defender] = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shot_req_q   <= 1'b1;
      sh_player    <= 1'b0;
      sh_x         <= '0;
      sh_y         <= '0;
      chk_range    <= 1'b0;
      chk_occ      <= 1'b0;
      chk_hit      <= 1'b0;
      place_ack    <= 1'b0;
      place_err    <= 1'b0;
      shot_done    <= 1'b0;
      acertou_tiro <= 1'b0;
      repeat_shot  <= 1'b0;
      invalid_shot <= 1'b0;
    end else if (clear) begin
      shot_req_q   <= 1'b1;
      sh_player    <= 1'b0;
      sh_x         <= '0;
      sh_y         <= '0;
      chk_range    <= 1'b0;
      chk_occ      <= 1'b0;
      chk_hit      <= 1'b0;
      place_ack    <= 1'b0;
      place_err    <= 1'b0;
      shot_done    <= 1'b0;
      acertou_tiro <= 1'b0;
      repeat_shot  <= 1'b0;
      invalid_shot <= 1'b0;
    end else begin
      shot_req_q <= shot_req;
      if (latch_shot) begin
        sh_player <= shot_player;
        sh_x      <= shot_x;
        sh_y      <= shot_y;
      end
      if (state == CHECK) begin
        chk_range <= in_range(sh_x, sh_y);
        chk_occ   <= occ_b[defender];
        chk_hit   <= hit_b[defender];
      end
      place_ack <= place_ok;
      place_err <= place_rej;
      shot_done <= res_done;
      if (res_done) begin
        acertou_tiro <= res_hit;
        repeat_shot  <= res_rep;
        invalid_shot <= res_inv;
      end
    end
  end

  assign busy   = (state != IDLE);
  assign qtd_p1 = count_b[0];
  assign qtd_p2 = count_b[1];

endmodule

// File: tb/tb_colisor_tiro.sv
// Self-checking bench for colisor_tiro: transaction-level board model compared every cycle, plus directed literals.
module tb_colisor_tiro;

  localparam int G  = 8;
  localparam int MX = 8;

  logic       clk;
  logic       reset;
  logic       clear;
  logic       place_we;
  logic       place_player;
  logic [3:0] place_x;
  logic [3:0] place_y;
  logic       place_ack;
  logic       place_err;
  logic       shot_req;
  logic       shot_player;
  logic [3:0] shot_x;
  logic [3:0] shot_y;
  logic       busy;
  logic       shot_done;
  logic       acertou_tiro;
  logic       repeat_shot;
  logic       invalid_shot;
  logic [3:0] qtd_p1;
  logic [3:0] qtd_p2;

  colisor_tiro dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .place_we     (place_we),
    .place_player (place_player),
    .place_x      (place_x),
    .place_y      (place_y),
    .place_ack    (place_ack),
    .place_err    (place_err),
    .shot_req     (shot_req),
    .shot_player  (shot_player),
    .shot_x       (shot_x),
    .shot_y       (shot_y),
    .busy         (busy),
    .shot_done    (shot_done),
    .acertou_tiro (acertou_tiro),
    .repeat_shot  (repeat_shot),
    .invalid_shot (invalid_shot),
    .qtd_p1       (qtd_p1),
    .qtd_p2       (qtd_p2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_done = 0;

  // Behavioural model: boards as plain arrays, a shot is a 2-cycle countdown
  bit m_occ [2][G*G];
  bit m_hit [2][G*G];
  int m_cnt [2];
  bit e_ack, e_err, e_done, e_hit, e_rep, e_inv;
  int stage;
  bit prev_req;
  bit m_idle, m_rise;
  int s_p, s_x, s_y, d, ci, pp, px, py;

  function automatic void check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endfunction

  function void model_clear();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < G*G; i++) begin
        m_occ[b][i] = 1'b0;
        m_hit[b][i] = 1'b0;
      end
      m_cnt[b] = 0;
    end
    e_ack = 0; e_err = 0; e_done = 0; e_hit = 0; e_rep = 0; e_inv = 0;
    stage = 0;
    prev_req = 1'b1;
  endfunction

  function void model_resolve();
    d = (s_p == 0) ? 1 : 0;
    e_done = 1;
    e_hit = 0; e_rep = 0; e_inv = 0;
    if (s_x >= G || s_y >= G) begin
      e_inv = 1;
    end else begin
      ci = s_y * G + s_x;
      if (m_occ[d][ci] && !m_hit[d][ci]) begin
        e_hit = 1;
        m_hit[d][ci] = 1;
        if (m_cnt[d] > 0) m_cnt[d] = m_cnt[d] - 1;
      end else if (m_occ[d][ci]) begin
        e_rep = 1;
      end else begin
        m_hit[d][ci] = 1;
      end
    end
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_clear();
    end else if (clear) begin
      model_clear();
    end else begin
      m_idle = (stage == 0);
      m_rise = shot_req && !prev_req;
      prev_req = shot_req;
      e_ack = 0; e_err = 0; e_done = 0;
      if (stage == 1) begin
        model_resolve();
        stage = 0;
      end else if (stage == 2) begin
        stage = 1;
      end else if (m_rise) begin
        s_p = int'(shot_player); s_x = int'(shot_x); s_y = int'(shot_y);
        stage = 2;
      end
      if (place_we) begin
        pp = int'(place_player); px = int'(place_x); py = int'(place_y);
        if (m_idle && !m_rise && px < G && py < G && !m_occ[pp][py*G+px] && m_cnt[pp] < MX) begin
          m_occ[pp][py*G+px] = 1;
          m_cnt[pp] = m_cnt[pp] + 1;
          e_ack = 1;
        end else begin
          e_err = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("place_ack", int'(place_ack), int'(e_ack));
    check("place_err", int'(place_err), int'(e_err));
    check("busy", int'(busy), (stage != 0) ? 1 : 0);
    check("shot_done", int'(shot_done), int'(e_done));
    check("acertou_tiro", int'(acertou_tiro), int'(e_hit));
    check("repeat_shot", int'(repeat_shot), int'(e_rep));
    check("invalid_shot", int'(invalid_shot), int'(e_inv));
    check("qtd_p1", int'(qtd_p1), m_cnt[0]);
    check("qtd_p2", int'(qtd_p2), m_cnt[1]);
    if (shot_done) n_done++;
  end

  task automatic place(input bit p, input int x, input int y, input bit want_ack);
    @(posedge clk); #1;
    place_we = 1'b1; place_player = p; place_x = 4'(x); place_y = 4'(y);
    @(posedge clk); #1;
    place_we = 1'b0;
    check("lit_place_ack", int'(place_ack), int'(want_ack));
    check("lit_place_err", int'(place_err), int'(!want_ack));
  endtask

  task automatic shot(input bit p, input int x, input int y);
    @(posedge clk); #1;
    shot_req = 1'b1; shot_player = p; shot_x = 4'(x); shot_y = 4'(y);
    @(posedge clk); #1;
    shot_req = 1'b0;
    check("lit_busy_check", int'(busy), 1);
    @(posedge clk); #1;
    check("lit_done_early", int'(shot_done), 0);
    @(posedge clk); #1;
    check("lit_done_rise2", int'(shot_done), 1);
  endtask

  function automatic logic [3:0] rcoord();
    if ($urandom_range(0, 9) == 0) return 4'($urandom_range(8, 15));
    return 4'($urandom_range(0, 4));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int d0;

  initial begin
    reset = 1'b0; clear = 1'b0;
    place_we = 1'b0; place_player = 1'b0; place_x = '0; place_y = '0;
    shot_req = 1'b0; shot_player = 1'b0; shot_x = '0; shot_y = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    check("lit_reset_qtd_p1", int'(qtd_p1), 0);
    check("lit_reset_busy", int'(busy), 0);

    place(1'b1, 2, 3, 1'b1);
    place(1'b1, 5, 5, 1'b1);
    check("lit_qtd_p2_two", int'(qtd_p2), 2);
    shot(1'b0, 2, 3);
    check("lit_hit", int'(acertou_tiro), 1);
    check("lit_qtd_p2_one", int'(qtd_p2), 1);

    shot(1'b0, 2, 3);
    check("lit_rep_hit", int'(acertou_tiro), 0);
    check("lit_rep", int'(repeat_shot), 1);
    check("lit_rep_qtd", int'(qtd_p2), 1);
    shot(1'b0, 0, 0);
    check("lit_miss_hit", int'(acertou_tiro), 0);
    check("lit_miss_rep", int'(repeat_shot), 0);
    check("lit_miss_inv", int'(invalid_shot), 0);

    shot(1'b1, 8, 8);
    check("lit_inv", int'(invalid_shot), 1);
    check("lit_inv_hit", int'(acertou_tiro), 0);
    check("lit_inv_qtd_p1", int'(qtd_p1), 0);
    place(1'b0, 8, 1, 1'b0);

    for (int i = 0; i < 8; i++) place(1'b0, i, 0, 1'b1);
    place(1'b0, 0, 1, 1'b0);
    check("lit_qtd_p1_full", int'(qtd_p1), 8);
    place(1'b1, 5, 5, 1'b0);
    check("lit_dup_qtd_p2", int'(qtd_p2), 1);

    d0 = n_done;
    @(posedge clk); #1;
    shot_req = 1'b1; shot_player = 1'b1; shot_x = 4'd7; shot_y = 4'd7;
    repeat (10) @(posedge clk);
    #1 shot_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("lit_hold_one_done", n_done - d0, 1);

    d0 = n_done;
    @(posedge clk); #1;
    shot_req = 1'b1; shot_player = 1'b0; shot_x = 4'd4; shot_y = 4'd4;
    @(posedge clk); #1 shot_req = 1'b0;
    @(posedge clk); #1 shot_req = 1'b1;
    @(posedge clk); #1 shot_req = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("lit_busy_rise_ignored", n_done - d0, 1);

    d0 = n_done;
    @(posedge clk); #1;
    shot_req = 1'b1; shot_player = 1'b0; shot_x = 4'd5; shot_y = 4'd5;
    @(posedge clk); #1;
    shot_req = 1'b0;
    reset = 1'b0;
    #1 check("lit_rst_busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    check("lit_rst_no_done", n_done - d0, 0);
    check("lit_rst_qtd_p1", int'(qtd_p1), 0);
    check("lit_rst_qtd_p2", int'(qtd_p2), 0);
    check("lit_rst_flag", int'(acertou_tiro), 0);
    shot(1'b0, 5, 5);
    check("lit_rst_miss", int'(acertou_tiro), 0);
    check("lit_rst_miss_rep", int'(repeat_shot), 0);

    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      clear        = ($urandom_range(0, 80) == 0);
      place_we     = ($urandom_range(0, 2) == 0);
      place_player = 1'($urandom_range(0, 1));
      place_x      = rcoord();
      place_y      = rcoord();
      shot_req     = 1'($urandom_range(0, 1));
      shot_player  = 1'($urandom_range(0, 1));
      shot_x       = rcoord();
      shot_y       = rcoord();
    end
    @(posedge clk); #1;
    clear = 1'b0; place_we = 1'b0; shot_req = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
